pipeline_ctrl: RTL and testbench

//   Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the
//   6-bit stall vector that drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_ctrl_pkg.sv | 37 +++
 rtl/pipeline_ctrl_stall_watchdog.sv | 34 +++
 rtl/pipeline_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, stall vector encodings and controller state codes for pipeline_ctrl.
package pipeline_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ADDR_W  = 32;

  // Stall bus bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_FLUSH   = 2'd1,
    CTRL_RECOVER = 2'd2
  } ctrl_state_e;

  function automatic logic [STALL_W-1:0] stall_encode(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [STALL_W-1:0] vec;
    if (req_mem)     vec = STALL_MEM;
    else if (req_ex) vec = STALL_EX;
    else if (req_id) vec = STALL_ID;
    else if (req_if) vec = STALL_IF;
    else             vec = STALL_NONE;
    return vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky flag once TIMEOUT is reached.
module pipeline_ctrl_stall_watchdog #(
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic stall_timeout
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Counter saturates at LIMIT; the flag is set on the edge where it gets there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!stalled)
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + ONE;

      if (stalled && (cnt == LIMIT_M1))
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall priority encoder, exception flush/recover sequencer, stall statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2,
  parameter int TIMEOUT        = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                excp_valid,
  input  logic [ADDR_W-1:0]   excp_handler,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                stall_timeout,
  output logic [31:0]         stall_cycles
);

  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  ctrl_state_e       state;
  logic [3:0]        rcnt;
  logic              flush_q;
  logic [ADDR_W-1:0] new_pc_q;
  logic              stalled;

  // Requests pass straight through except during the flush cycle
  always_comb begin
    stall = STALL_NONE;
    if (state != CTRL_FLUSH)
      stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
  end

  assign stalled = (stall != STALL_NONE);
  assign flush   = flush_q;
  assign new_pc  = new_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CTRL_RUN;
      rcnt     <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= ZERO_WORD;
    end else begin
      case (state)
        CTRL_RUN: begin
          if (excp_valid) begin
            state    <= CTRL_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= excp_handler;
          end
        end
        CTRL_FLUSH: begin
          state    <= CTRL_RECOVER;
          flush_q  <= 1'b0;
          new_pc_q <= ZERO_WORD;
          rcnt     <= RECOVER_LOAD;
        end
        CTRL_RECOVER: begin
          // Shadow window runs on wall-clock cycles, stalls do not extend it
          if (rcnt == 4'd0)
            state <= CTRL_RUN;
          else
            rcnt <= rcnt - 4'd1;
        end
        default: begin
          state    <= CTRL_RUN;
          flush_q  <= 1'b0;
          new_pc_q <= ZERO_WORD;
          rcnt     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (stalled)
      stall_cycles <= stall_cycles + 32'd1;
  end

  pipeline_ctrl_stall_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stalled       (stalled),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipeline_ctrl;

  localparam int RC = 2;
  localparam int TO = 8;
  localparam int CW = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_handler = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  pipeline_ctrl #(.RECOVER_CYCLES(RC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_handler  (excp_handler),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flush flag, remaining shadow cycles, stall run length
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_shadow;
  int          m_run;
  bit          m_to;
  logic [31:0] m_cycles;

  function automatic logic [5:0] model_stall();
    int depth;
    depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    if (m_flush) return 6'b0;
    return 6'((1 << depth) - 1);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [5:0] s;
    if (!rst) begin
      m_flush  = 1'b0;
      m_pc     = 32'h0;
      m_shadow = 0;
      m_run    = 0;
      m_to     = 1'b0;
      m_cycles = 32'h0;
    end else begin
      s = model_stall();
      if (s != 6'b0) begin
        m_run    = m_run + 1;
        m_cycles = m_cycles + 32'd1;
        if (m_run >= TO) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
      if (m_flush) begin
        m_flush  = 1'b0;
        m_pc     = 32'h0;
        m_shadow = RC;
      end else if (m_shadow > 0) begin
        m_shadow = m_shadow - 1;
      end else if (excp_valid) begin
        m_flush = 1'b1;
        m_pc    = excp_handler;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_stall", 32'(stall), 32'(model_stall()));
    chk("m_flush", 32'(flush), 32'(m_flush));
    chk("m_new_pc", new_pc, m_pc);
    chk("m_timeout", 32'(stall_timeout), 32'(m_to));
    chk("m_cycles", stall_cycles, m_cycles);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    chk("rst_cycles", stall_cycles, 32'h0);
    rst = 1'b1;
    cyc();

    // 1: ID stall for three cycles
    stallreq_id = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_stall", 32'(stall), 32'h07);
      cyc();
    end
    stallreq_id = 1'b0;
    @(negedge clk);
    chk("t1_release", 32'(stall), 32'h00);
    chk("t1_cycles", stall_cycles, 32'd3);

    // 2: IF+MEM, then MEM drops mid-cycle
    cyc();
    stallreq_if = 1'b1;
    stallreq_mem = 1'b1;
    @(negedge clk);
    chk("t2_mem_prio", 32'(stall), 32'h1F);
    #1 stallreq_mem = 1'b0;
    #1 chk("t2_drop_mem", 32'(stall), 32'h03);
    cyc();
    stallreq_if = 1'b0;

    // 3: exception, flush ignores stalls, two recover cycles then RUN
    excp_valid = 1'b1;
    excp_handler = 32'h0000_0100;
    cyc();
    excp_valid = 1'b0;
    stallreq_mem = 1'b1;
    @(negedge clk);
    chk("t3_flush", 32'(flush), 32'h1);
    chk("t3_new_pc", new_pc, 32'h100);
    chk("t3_flush_stall", 32'(stall), 32'h0);
    cyc();
    stallreq_mem = 1'b0;
    @(negedge clk);
    chk("t3_rec1_flush", 32'(flush), 32'h0);
    chk("t3_rec1_pc", new_pc, 32'h0);
    cyc();
    excp_valid = 1'b1;
    excp_handler = 32'h0000_0180;
    @(negedge clk);
    chk("t3_rec2_flush", 32'(flush), 32'h0);
    cyc();
    @(negedge clk);
    chk("t3_run_flush", 32'(flush), 32'h0);
    cyc();
    excp_valid = 1'b0;
    @(negedge clk);
    chk("t3_reflush", 32'(flush), 32'h1);
    chk("t3_reflush_pc", new_pc, 32'h180);

    // 4: exception in shadow is dropped, EX stall honoured
    cyc();
    stallreq_ex = 1'b1;
    excp_valid = 1'b1;
    excp_handler = 32'h0000_0200;
    @(negedge clk);
    chk("t4_rec1_stall", 32'(stall), 32'h0F);
    chk("t4_rec1_flush", 32'(flush), 32'h0);
    cyc();
    excp_valid = 1'b0;
    @(negedge clk);
    chk("t4_rec2_stall", 32'(stall), 32'h0F);
    cyc();
    @(negedge clk);
    chk("t4_no_flush", 32'(flush), 32'h0);
    cyc();
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("t4_still_no_flush", 32'(flush), 32'h0);

    // 5: watchdog
    cyc();
    stallreq_mem = 1'b1;
    repeat (TO) begin
      @(negedge clk);
      chk("t5_pre", 32'(stall_timeout), 32'h0);
      cyc();
    end
    @(negedge clk);
    chk("t5_set", 32'(stall_timeout), 32'h1);
    stallreq_mem = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("t5_sticky", 32'(stall_timeout), 32'h1);

    // 6: reset in the middle of a flush cycle
    cyc();
    excp_valid = 1'b1;
    excp_handler = 32'h0000_03C0;
    cyc();
    excp_valid = 1'b0;
    @(negedge clk);
    chk("t6_flush", 32'(flush), 32'h1);
    chk("t6_pc", new_pc, 32'h3C0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_flush", 32'(flush), 32'h0);
    chk("t6_rst_pc", new_pc, 32'h0);
    chk("t6_rst_stall", 32'(stall), 32'h0);
    chk("t6_rst_timeout", 32'(stall_timeout), 32'h0);
    chk("t6_rst_cycles", stall_cycles, 32'h0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_after_flush", 32'(flush), 32'h0);
    cyc();
    @(negedge clk);
    chk("t6_discarded", 32'(flush), 32'h0);
    excp_valid = 1'b1;
    excp_handler = 32'h0000_0044;
    cyc();
    excp_valid = 1'b0;
    @(negedge clk);
    chk("t6_run_flush", 32'(flush), 32'h1);
    chk("t6_run_pc", new_pc, 32'h44);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish, expected finish before 200000");
    $fatal(1, "time limit");
  end

endmodule
